vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised successor to the fixed 1024x768 VGA driver. It generates HS/VS/DE and active-area pixel coordinates for any timing set via parameters. It runs at a pixel rate gated by a clock-enable, so the system clock does not need to equal the pixel clock. It only starts and stops on frame boundaries, and it emits line, frame and vblank strobes for the game renderer and sprite-update logic.

## Interface
- H_SYNC, 136: horizontal sync width, pixels
- H_BP, 160: horizontal back porch
- H_ACTIVE, 1024: horizontal active pixels
- H_FP, 24: horizontal front porch
- V_SYNC, 6: vertical sync width, lines
- V_BP, 29: vertical back porch
- V_ACTIVE, 768: vertical active lines
- V_FP, 3: vertical front porch
- HS_POL, 0: asserted level of hs
- VS_POL, 0: asserted level of vs
- CW, 11: counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FW, 16: frame counter width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock-enable; counters advance only when 1
- en  in  1  run request; sampled on pix_ce cycles
- hs  out  1  horizontal sync at HS_POL level while asserted
- vs  out  1  vertical sync at VS_POL level while asserted
- de  out  1  active-video (data enable)
- x  out  CW  active-relative column, 0..H_ACTIVE-1; 0 when de=0
- y  out  CW  active-relative row, 0..V_ACTIVE-1; 0 when de=0
- line_start  out  1  one-clk strobe, first pixel of every line
- frame_start  out  1  one-clk strobe at h=0,v=0
- vblank  out  1  one-clk strobe on first pixel after last active pixel of frame
- frame_cnt  out  FW  completed-frame count, wraps
- running  out  1  FSM not in IDLE

## Operation
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL defined the same way.
- Line order: sync, back porch, active, front porch.
- Active window: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1], v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Counter advance (pix_ce=1 and state≠IDLE):
  - h increments; at H_TOTAL-1 it wraps to 0.
  - v increments on the h wrap; at V_TOTAL-1 it wraps to 0.
- hs asserted for h<H_SYNC; vs asserted for v<V_SYNC. Otherwise both sit at the inverse polarity.
- x = h-(H_SYNC+H_BP) and y = v-(V_SYNC+V_BP) inside the window; both 0 outside it.
- frame_cnt increments by 1 (mod 2^FW) on each v wrap from V_TOTAL-1 to 0.
- FSM:
  - IDLE: h=v=0; hs/vs deasserted; de=0; x=y=0; no strobes. On pix_ce && en, go to RUN; that ce cycle registers position (0,0).
  - RUN: normal counting. On pix_ce && !en, go to DRAIN.
  - DRAIN: keeps counting. On pix_ce && en, return to RUN with no disturbance. On pix_ce at h=H_TOTAL-1, v=V_TOTAL-1, go to IDLE; frame_cnt still increments.
- Frames are always complete: no partial frame is ever output, except after a reset.

## Timing
- Reset (async, rst_n=0):
  - hs=!HS_POL, vs=!VS_POL, de=0, x=y=0.
  - All strobes 0; frame_cnt=0; running=0; state IDLE; h=v=0.
  - Reset mid-frame aborts immediately with no drain.
- All outputs are registered. They update only on clk edges where pix_ce=1 and reflect the counter position of that edge.
- Latency is one pix_ce cycle from counter value to outputs.
- Strobes (line_start, frame_start, vblank):
  - High for exactly one clk, on the clk after the registering pix_ce edge.
  - Forced low on the next clk even if pix_ce stays low.
  - With pix_ce tied 1 they are one pixel wide.
- Simultaneous events at h=0,v=0: frame_start and line_start assert in the same cycle.
- running rises on the same edge that registers (0,0) after IDLE. It falls on the edge after the final pixel of the last frame.
- pix_ce=0: every output holds its value, except strobes, which clear.

## Test plan
- Small timing (H 4/2/8/2 = 16, V 2/1/4/1 = 8), pix_ce=1, en=1 from reset release:
  - hs low for 4 clk of every 16; vs low for 32 clk of every 128.
  - de high for 8 clk on 4 lines per frame.
  - x runs 0..7 and y runs 0..3.
  - frame_start every 128 clk; frame_cnt increments at each wrap.
- Same setup, en dropped mid-frame (v=3):
  - Output continues to h=15, v=7, then running=0 and hs/vs stay deasserted.
  - frame_cnt=prior+1.
  - Re-raise en: first output is h=0,v=0 with frame_start=1.
- en toggled low then high within one frame: no gap in the hs/de pattern; running stays 1.
- pix_ce=1 every 3rd clk:
  - All periods scale ×3.
  - Strobes still exactly one clk wide.
  - x/y/hs hold between enables.
- rst_n pulsed low at x=5, y=2:
  - Outputs take reset values asynchronously, before the next clk edge.
  - Restart begins at (0,0) with frame_cnt=0.
- Default 1024x768 parameters with HS_POL=VS_POL=1:
  - 1344 clk per line, 806 lines per frame.
  - hs high 136 clk; vs high 6 lines.
  - de high for first pixel at h=296, v=35, where x=0, y=0.
  - vblank strobe at h=1320, v=802.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces hs/vs/de, active-relative coordinates and line/frame/vblank
// strobes at a pixel rate set by pix_ce. Starts and stops only on frame
// boundaries so downstream logic never sees a truncated frame.
module vga_timing_gen #(
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11,
  parameter int FW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank,
  output logic [FW-1:0] frame_cnt,
  output logic          running
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_BEG = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] HA_END = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] VA_BEG = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] VA_END = CW'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] h, v;       // position currently on the outputs
  logic [CW-1:0] h_n, v_n;   // position registered on the next pix_ce edge
  logic          at_last;    // last pixel of the frame is on the outputs
  logic          advance;    // counters step this edge
  logic          on_n;       // next registered position is a real pixel
  logic          win_n;      // next position lies in the active window

  // Next position and next FSM state; stopping is only allowed at frame end.
  always_comb begin
    state_n = state;
    h_n     = h;
    v_n     = v;
    at_last = (h == H_LAST) && (v == V_LAST);
    advance = pix_ce && (state != IDLE);
    if (advance) begin
      if (h == H_LAST) begin
        h_n = '0;
        v_n = (v == V_LAST) ? '0 : v + CW'(1);
      end else begin
        h_n = h + CW'(1);
      end
    end
    case (state)
      IDLE:    if (pix_ce && en) state_n = RUN;
      RUN:     if (pix_ce && !en) state_n = at_last ? IDLE : DRAIN;
      DRAIN: begin
        if (pix_ce) begin
          if (en)           state_n = RUN;
          else if (at_last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    on_n  = (state_n != IDLE);
    win_n = (h_n >= HA_BEG) && (h_n <= HA_END) &&
            (v_n >= VA_BEG) && (v_n <= VA_END);
  end

  // State and position registers, stepping only on pixel enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h     <= '0;
      v     <= '0;
    end else if (pix_ce) begin
      state <= state_n;
      h     <= h_n;
      v     <= v_n;
    end
  end

  // Registered outputs; strobes self-clear on every clk so they stay one clk wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      frame_cnt   <= '0;
      running     <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      if (pix_ce) begin
        hs          <= (on_n && (h_n < HS_END)) ? HS_POL : ~HS_POL;
        vs          <= (on_n && (v_n < VS_END)) ? VS_POL : ~VS_POL;
        de          <= on_n && win_n;
        x           <= (on_n && win_n) ? h_n - HA_BEG : '0;
        y           <= (on_n && win_n) ? v_n - VA_BEG : '0;
        line_start  <= on_n && (h_n == '0);
        frame_start <= on_n && (h_n == '0) && (v_n == '0);
        vblank      <= on_n && advance && (h == HA_END) && (v == VA_END);
        running     <= on_n;
        if (advance && at_last) frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small 16x8 raster for the control
// behaviour and a default-timing instance for the 1024x768 landmarks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n, pix_ce, en, b_en;

  logic       hs, vs, de, line_start, frame_start, vblank, running;
  logic [5:0] x, y;
  logic [7:0] frame_cnt;

  logic        b_hs, b_vs, b_de, b_ls, b_fs, b_vb, b_run;
  logic [10:0] b_x, b_y;
  logic [15:0] b_fc;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(4), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(6), .FW(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .en(en),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .vblank(vblank),
    .frame_cnt(frame_cnt), .running(running)
  );

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) u_big (
    .clk(clk), .rst_n(rst_n), .pix_ce(1'b1), .en(b_en),
    .hs(b_hs), .vs(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .vblank(b_vb),
    .frame_cnt(b_fc), .running(b_run)
  );

  int n_pass = 0;
  int n_total = 0;

  // window statistics for the small instance
  int w_hs, w_vs, w_de, w_ls, w_fs, w_vb, w_maxx, w_maxy, w_xsum, w_runlo, w_hold;
  logic [5:0] prev_x, prev_y;
  logic       prev_hs;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wclr();
    w_hs = 0; w_vs = 0; w_de = 0; w_ls = 0; w_fs = 0; w_vb = 0;
    w_maxx = 0; w_maxy = 0; w_xsum = 0; w_runlo = 0; w_hold = 0;
  endtask

  task automatic tick();
    logic ce_used;
    ce_used = pix_ce;
    @(posedge clk);
    #1;
    if (hs == 1'b0) w_hs++;
    if (vs == 1'b0) w_vs++;
    if (de) begin
      w_de++;
      w_xsum += int'(x);
      if (int'(x) > w_maxx) w_maxx = int'(x);
      if (int'(y) > w_maxy) w_maxy = int'(y);
    end
    if (line_start) w_ls++;
    if (frame_start) w_fs++;
    if (vblank) w_vb++;
    if (!running) w_runlo++;
    if (!ce_used && (x !== prev_x || y !== prev_y || hs !== prev_hs ||
                     line_start || frame_start || vblank)) w_hold++;
    prev_x = x; prev_y = y; prev_hs = hs;
  endtask

  initial begin
    int n, cnt;
    rst_n = 1'b0; en = 1'b0; pix_ce = 1'b0; b_en = 1'b0;
    prev_x = '0; prev_y = '0; prev_hs = 1'b1;
    wclr();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_de", de, 0);
    chk("rst_x", x, 0);
    chk("rst_running", running, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_strobes", {line_start, frame_start, vblank}, 0);
    chk("rst_big_hs", b_hs, 0);

    // start: first edge registers (0,0)
    rst_n = 1'b1; en = 1'b1; pix_ce = 1'b1;
    tick();
    chk("start_running", running, 1);
    chk("start_frame_start", frame_start, 1);
    chk("start_line_start", line_start, 1);
    chk("start_hs", hs, 0);
    chk("start_vs", vs, 0);
    chk("start_de", de, 0);
    repeat (54) tick();  // position (6,3): first active pixel
    chk("first_de", de, 1);
    chk("first_x", x, 0);
    chk("first_y", y, 0);

    // one full frame of statistics
    wclr();
    repeat (128) tick();
    chk("frame_hs_low", w_hs, 32);
    chk("frame_vs_low", w_vs, 32);
    chk("frame_de", w_de, 32);
    chk("frame_ls", w_ls, 8);
    chk("frame_fs", w_fs, 1);
    chk("frame_vb", w_vb, 1);
    chk("frame_maxx", w_maxx, 7);
    chk("frame_maxy", w_maxy, 3);
    chk("frame_xsum", w_xsum, 112);
    chk("frame_cnt1", frame_cnt, 1);

    // drop en at v=3: drain to end of frame, then idle
    en = 1'b0;
    n = 0;
    do begin tick(); n++; end while (running && n < 300);
    chk("drain_cycles", n, 74);
    chk("drain_frame_cnt", frame_cnt, 2);
    chk("drain_hs", hs, 1);
    chk("drain_vs", vs, 1);
    chk("drain_de", de, 0);
    wclr();
    repeat (5) tick();
    chk("idle_runlo", w_runlo, 5);
    chk("idle_hs_low", w_hs, 0);
    en = 1'b1;
    tick();
    chk("restart_fs", frame_start, 1);
    chk("restart_running", running, 1);
    chk("restart_hs", hs, 0);

    // en low then high within a frame: no gap
    repeat (20) tick();
    wclr();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    repeat (118) tick();
    chk("toggle_runlo", w_runlo, 0);
    chk("toggle_hs_low", w_hs, 32);
    chk("toggle_de", w_de, 32);
    chk("toggle_fs", w_fs, 1);
    chk("toggle_frame_cnt", frame_cnt, 3);

    // pix_ce every third clk
    wclr();
    for (int k = 0; k < 384; k++) begin
      pix_ce = (k % 3 == 0);
      tick();
    end
    pix_ce = 1'b1;
    chk("ce3_hs_low", w_hs, 96);
    chk("ce3_vs_low", w_vs, 96);
    chk("ce3_de", w_de, 96);
    chk("ce3_ls", w_ls, 8);
    chk("ce3_fs", w_fs, 1);
    chk("ce3_vb", w_vb, 1);
    chk("ce3_hold", w_hold, 0);
    chk("ce3_frame_cnt", frame_cnt, 4);

    // async reset at x=5,y=2
    n = 0;
    do begin tick(); n++; end while (!(de && x == 6'd5 && y == 6'd2) && n < 400);
    chk("find_x5y2", int'(de && x == 6'd5 && y == 6'd2), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_hs", hs, 1);
    chk("arst_vs", vs, 1);
    chk("arst_de", de, 0);
    chk("arst_x", x, 0);
    chk("arst_y", y, 0);
    chk("arst_running", running, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rerun_fs", frame_start, 1);
    chk("rerun_hs", hs, 0);
    chk("rerun_frame_cnt", frame_cnt, 0);

    // default 1024x768 timing, positive sync
    b_en = 1'b1;
    tick();
    chk("big_hs", b_hs, 1);
    chk("big_vs", b_vs, 1);
    chk("big_fs", b_fs, 1);
    cnt = int'(b_hs);
    n = 0;
    do begin
      tick(); n++;
      if (!b_ls) cnt += int'(b_hs);
    end while (!b_ls && n < 3000);
    chk("big_line_len", n, 1344);
    chk("big_hs_width", cnt, 136);
    n = 0;
    while (b_vs && n < 10000) begin tick(); n++; end
    chk("big_vs_end", n, 6720);
    n = 0;
    while (!b_de && n < 50000) begin tick(); n++; end
    chk("big_first_de", n, 39272);
    chk("big_first_x", b_x, 0);
    chk("big_first_y", b_y, 0);
    tick();
    chk("big_second_x", b_x, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
